// File: rtl/chimera_cluster_isolator.sv
`default_nettype none
// ============================================================================
// | Module   : chimera_cluster_isolator
// | Brief    : AXI isolate/drain stage in front of a cluster's SoC slave port.
// |            Optional ISOLATED-state error responder: CHIMERA_ISOLATOR_ERR_RESP_EN
// | Revision : 1.0 - initial release
// ============================================================================

package chimera_cluster_isolator_pkg;
  typedef logic [3:0]  id_t;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } ax_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_resp_t;
endpackage

module chimera_cluster_isolator
  import chimera_cluster_isolator_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1),
  parameter type         req_t          = axi_req_t,
  parameter type         resp_t         = axi_resp_t
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                isolate_i,
  output logic                isolated_o,
  input  req_t                slv_req_i,
  output resp_t               slv_resp_o,
  output req_t                mst_req_o,
  input  resp_t               mst_resp_i,
  output logic [CntWidth-1:0] wr_outstanding_o,
  output logic [CntWidth-1:0] rd_outstanding_o
);

  localparam logic [1:0]          c_ST_RUN   = 2'd0;
  localparam logic [1:0]          c_ST_DRAIN = 2'd1;
  localparam logic [1:0]          c_ST_ISO   = 2'd2;
  localparam logic [CntWidth-1:0] c_MAX      = CntWidth'(MaxOutstanding);
  localparam logic [CntWidth-1:0] c_ONE      = CntWidth'(1);
  localparam logic [CntWidth:0]   c_PEND_ONE = (CntWidth + 1)'(1);

  logic [1:0]          r_state, w_state_nxt;
  logic [CntWidth-1:0] r_wr_cnt, r_rd_cnt;
  logic [CntWidth:0]   r_w_pend;
  logic                r_aw_hold, r_ar_hold;

  logic w_live, w_run, w_drain, w_iso, w_pass;
  logic w_aw_fwd, w_ar_fwd;
  logic w_mst_aw_valid, w_mst_ar_valid, w_mst_w_valid, w_mst_b_ready, w_mst_r_ready;
  logic w_aw_hs, w_ar_hs, w_wlast_hs, w_b_hs, w_rlast_hs;
  logic w_drained, w_err_idle;

  // Outputs are forced quiet while reset is held, independent of upstream inputs.
  assign w_live  = ~rst_i;
  assign w_run   = (r_state == c_ST_RUN);
  assign w_drain = (r_state == c_ST_DRAIN);
  assign w_iso   = (r_state == c_ST_ISO);
  assign w_pass  = w_live & (w_run | w_drain);

  // An address already presented downstream keeps being forwarded until accepted.
  assign w_aw_fwd = w_live & ((w_run & (r_wr_cnt != c_MAX)) | (w_drain & r_aw_hold));
  assign w_ar_fwd = w_live & ((w_run & (r_rd_cnt != c_MAX)) | (w_drain & r_ar_hold));

  assign w_mst_aw_valid = slv_req_i.aw_valid & w_aw_fwd;
  assign w_mst_ar_valid = slv_req_i.ar_valid & w_ar_fwd;
  assign w_mst_w_valid  = slv_req_i.w_valid & w_pass;
  assign w_mst_b_ready  = w_pass ? slv_req_i.b_ready : w_iso;
  assign w_mst_r_ready  = w_pass ? slv_req_i.r_ready : w_iso;

  assign w_aw_hs    = w_mst_aw_valid & mst_resp_i.aw_ready;
  assign w_ar_hs    = w_mst_ar_valid & mst_resp_i.ar_ready;
  assign w_wlast_hs = w_mst_w_valid & mst_resp_i.w_ready & slv_req_i.w.last;
  assign w_b_hs     = mst_resp_i.b_valid & w_mst_b_ready;
  assign w_rlast_hs = mst_resp_i.r_valid & w_mst_r_ready & mst_resp_i.r.last;

  assign w_drained = (r_wr_cnt == '0) && (r_rd_cnt == '0) && (r_w_pend == '0) &&
                     !r_aw_hold && !r_ar_hold;

  assign wr_outstanding_o = r_wr_cnt;
  assign rd_outstanding_o = r_rd_cnt;
  assign isolated_o       = w_iso;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_w_pend  <= '0;
      r_aw_hold <= 1'b0;
      r_ar_hold <= 1'b0;
    end else begin
      case ({w_aw_hs, w_b_hs})
        2'b10:   r_wr_cnt <= r_wr_cnt + c_ONE;
        2'b01:   if (r_wr_cnt != '0) r_wr_cnt <= r_wr_cnt - c_ONE;
        default: r_wr_cnt <= r_wr_cnt;
      endcase
      case ({w_ar_hs, w_rlast_hs})
        2'b10:   r_rd_cnt <= r_rd_cnt + c_ONE;
        2'b01:   if (r_rd_cnt != '0) r_rd_cnt <= r_rd_cnt - c_ONE;
        default: r_rd_cnt <= r_rd_cnt;
      endcase
      // W may legally lead its AW, so this difference is kept as two's complement.
      case ({w_aw_hs, w_wlast_hs})
        2'b10:   r_w_pend <= r_w_pend + c_PEND_ONE;
        2'b01:   r_w_pend <= r_w_pend - c_PEND_ONE;
        default: r_w_pend <= r_w_pend;
      endcase
      r_aw_hold <= w_mst_aw_valid & ~mst_resp_i.aw_ready;
      r_ar_hold <= w_mst_ar_valid & ~mst_resp_i.ar_ready;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= c_ST_RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_RUN:   if (isolate_i) w_state_nxt = c_ST_DRAIN;
      c_ST_DRAIN: begin
        if (!isolate_i)     w_state_nxt = c_ST_RUN;
        else if (w_drained) w_state_nxt = c_ST_ISO;
      end
      c_ST_ISO:   if (!isolate_i && w_err_idle) w_state_nxt = c_ST_RUN;
      default:    w_state_nxt = c_ST_RUN;
    endcase
  end

`ifdef CHIMERA_ISOLATOR_ERR_RESP_EN
  localparam logic [1:0] c_EW_IDLE = 2'd0;
  localparam logic [1:0] c_EW_DATA = 2'd1;
  localparam logic [1:0] c_EW_RESP = 2'd2;

  logic [1:0] r_ew_state, w_ew_state_nxt;
  id_t        r_ew_id, r_er_id;
  logic       r_er_busy;
  logic [7:0] r_er_left;
  logic       w_err_accept, w_ew_aw_ready, w_er_ar_ready;

  // New error transactions are only taken while isolation is still requested.
  assign w_err_accept  = w_live & w_iso & isolate_i;
  assign w_ew_aw_ready = w_err_accept & (r_ew_state == c_EW_IDLE);
  assign w_er_ar_ready = w_err_accept & ~r_er_busy;
  assign w_err_idle    = (r_ew_state == c_EW_IDLE) & ~r_er_busy;

  always_comb begin
    w_ew_state_nxt = r_ew_state;
    case (r_ew_state)
      c_EW_IDLE: if (slv_req_i.aw_valid && w_ew_aw_ready) w_ew_state_nxt = c_EW_DATA;
      c_EW_DATA: if (slv_req_i.w_valid && slv_req_i.w.last) w_ew_state_nxt = c_EW_RESP;
      c_EW_RESP: if (slv_req_i.b_ready) w_ew_state_nxt = c_EW_IDLE;
      default:   w_ew_state_nxt = c_EW_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ew_state <= c_EW_IDLE;
      r_ew_id    <= '0;
      r_er_busy  <= 1'b0;
      r_er_id    <= '0;
      r_er_left  <= '0;
    end else begin
      r_ew_state <= w_ew_state_nxt;
      if (slv_req_i.aw_valid && w_ew_aw_ready) r_ew_id <= slv_req_i.aw.id;
      if (slv_req_i.ar_valid && w_er_ar_ready) begin
        r_er_busy <= 1'b1;
        r_er_id   <= slv_req_i.ar.id;
        r_er_left <= slv_req_i.ar.len;
      end else if (r_er_busy && slv_req_i.r_ready) begin
        if (r_er_left == '0) r_er_busy <= 1'b0;
        else                 r_er_left <= r_er_left - 8'd1;
      end
    end
  end
`else
  assign w_err_idle = 1'b1;
`endif

  always_comb begin
    mst_req_o          = '0;
    mst_req_o.aw       = slv_req_i.aw;
    mst_req_o.w        = slv_req_i.w;
    mst_req_o.ar       = slv_req_i.ar;
    mst_req_o.aw_valid = w_mst_aw_valid;
    mst_req_o.ar_valid = w_mst_ar_valid;
    mst_req_o.w_valid  = w_mst_w_valid;
    mst_req_o.b_ready  = w_mst_b_ready;
    mst_req_o.r_ready  = w_mst_r_ready;

    slv_resp_o          = '0;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & w_aw_fwd;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & w_ar_fwd;
    slv_resp_o.w_ready  = mst_resp_i.w_ready & w_pass;
    slv_resp_o.b_valid  = mst_resp_i.b_valid & w_pass;
    slv_resp_o.b        = mst_resp_i.b;
    slv_resp_o.r_valid  = mst_resp_i.r_valid & w_pass;
    slv_resp_o.r        = mst_resp_i.r;
`ifdef CHIMERA_ISOLATOR_ERR_RESP_EN
    if (w_iso) begin
      slv_resp_o.aw_ready = w_ew_aw_ready;
      slv_resp_o.w_ready  = (r_ew_state == c_EW_DATA);
      slv_resp_o.b_valid  = (r_ew_state == c_EW_RESP);
      slv_resp_o.b.id     = r_ew_id;
      slv_resp_o.b.resp   = 2'b10;
      slv_resp_o.ar_ready = w_er_ar_ready;
      slv_resp_o.r_valid  = r_er_busy;
      slv_resp_o.r.id     = r_er_id;
      slv_resp_o.r.data   = '0;
      slv_resp_o.r.resp   = 2'b10;
      slv_resp_o.r.last   = r_er_busy & (r_er_left == '0);
    end
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_chimera_cluster_isolator.sv
`default_nettype none
// ============================================================================
// | Module   : tb_chimera_cluster_isolator
// | Brief    : Directed self-checking bench for chimera_cluster_isolator.
// | Revision : 1.0 - initial release
// ============================================================================

module tb_chimera_cluster_isolator;
  import chimera_cluster_isolator_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       isolate;
  logic       isolated;
  axi_req_t   slv_req, mst_req;
  axi_resp_t  slv_resp, mst_resp;
  logic [3:0] wr_out, rd_out;
  int         n_total = 0;
  int         n_bad   = 0;

  always #5 clk = ~clk;

  chimera_cluster_isolator #(.MaxOutstanding(8)) u_dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .isolate_i        (isolate),
    .isolated_o       (isolated),
    .slv_req_i        (slv_req),
    .slv_resp_o       (slv_resp),
    .mst_req_o        (mst_req),
    .mst_resp_i       (mst_resp),
    .wr_outstanding_o (wr_out),
    .rd_outstanding_o (rd_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    slv_req  = '0;
    mst_resp = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset: quiet outputs even with upstream valid and downstream ready high
    rst     = 1'b1;
    isolate = 1'b0;
    clear_inputs();
    mst_resp.aw_ready = 1'b1;
    slv_req.aw_valid  = 1'b1;
    #12;
    chk("rst_isolated", isolated, 0);
    chk("rst_wr_cnt", wr_out, 0);
    chk("rst_rd_cnt", rd_out, 0);
    chk("rst_slv_aw_ready", slv_resp.aw_ready, 0);
    chk("rst_mst_aw_valid", mst_req.aw_valid, 0);
    clear_inputs();
    tick();
    rst = 1'b0;
    tick();

    // Idle isolate: DRAIN after one edge, ISOLATED after the second
    isolate = 1'b1;
    tick(); settle();
    chk("idle_iso_drain", isolated, 0);
    tick(); settle();
    chk("idle_iso_rise", isolated, 1);
    chk("iso_mst_b_ready", mst_req.b_ready, 1);
`ifdef CHIMERA_ISOLATOR_ERR_RESP_EN
    slv_req.ar.id = 4'd5; slv_req.ar.len = 8'd3; slv_req.ar_valid = 1'b1;
    settle();
    chk("err_ar_ready", slv_resp.ar_ready, 1);
    chk("err_mst_ar_valid", mst_req.ar_valid, 0);
    tick();
    slv_req.ar_valid = 1'b0;
    slv_req.r_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("err_r_valid", slv_resp.r_valid, 1);
      chk("err_r_id", slv_resp.r.id, 5);
      chk("err_r_resp", slv_resp.r.resp, 2);
      chk("err_r_last", slv_resp.r.last, (i == 3) ? 1 : 0);
      tick();
    end
    settle();
    chk("err_r_done", slv_resp.r_valid, 0);
    slv_req.r_ready = 1'b0;
    slv_req.aw.id = 4'd6; slv_req.aw.len = 8'd1; slv_req.aw_valid = 1'b1;
    settle();
    chk("err_aw_ready", slv_resp.aw_ready, 1);
    tick();
    slv_req.aw_valid = 1'b0;
    slv_req.w_valid  = 1'b1;
    slv_req.w.last   = 1'b0;
    settle();
    chk("err_w0_ready", slv_resp.w_ready, 1);
    chk("err_mst_w_valid", mst_req.w_valid, 0);
    tick();
    slv_req.w.last = 1'b1;
    settle();
    chk("err_w1_ready", slv_resp.w_ready, 1);
    tick();
    slv_req.w_valid = 1'b0;
    slv_req.b_ready = 1'b1;
    settle();
    chk("err_b_valid", slv_resp.b_valid, 1);
    chk("err_b_resp", slv_resp.b.resp, 2);
    chk("err_b_id", slv_resp.b.id, 6);
    tick(); settle();
    chk("err_b_done", slv_resp.b_valid, 0);
    slv_req.b_ready = 1'b0;
`else
    mst_resp.aw_ready = 1'b1;
    slv_req.aw_valid  = 1'b1;
    slv_req.ar_valid  = 1'b1;
    settle();
    chk("iso_slv_aw_ready", slv_resp.aw_ready, 0);
    chk("iso_slv_ar_ready", slv_resp.ar_ready, 0);
    chk("iso_mst_aw_valid", mst_req.aw_valid, 0);
    clear_inputs();
`endif
    isolate = 1'b0;
    settle();
    chk("iso_before_fall", isolated, 1);
    tick(); settle();
    chk("iso_fall", isolated, 0);

    // Drain: three reads outstanding before isolation
    clear_inputs();
    mst_resp.ar_ready = 1'b1;
    slv_req.ar_valid  = 1'b1;
    tick(); tick(); tick();
    slv_req.ar_valid = 1'b0;
    settle();
    chk("drain_rd3", rd_out, 3);
    isolate = 1'b1;
    tick();
    slv_req.ar_valid = 1'b1;
    settle();
    chk("drain_ar_gated", mst_req.ar_valid, 0);
    chk("drain_ar_ready", slv_resp.ar_ready, 0);
    mst_resp.r_valid = 1'b1;
    mst_resp.r.id    = 4'd2;
    mst_resp.r.last  = 1'b0;
    slv_req.r_ready  = 1'b1;
    settle();
    chk("drain_r_pass", slv_resp.r_valid, 1);
    tick(); settle();
    chk("drain_r_notlast", rd_out, 3);
    mst_resp.r.last = 1'b1;
    tick(); settle();
    chk("drain_rd2", rd_out, 2);
    chk("drain_not_iso", isolated, 0);
    tick(); tick();
    mst_resp.r_valid = 1'b0;
    settle();
    chk("drain_rd0", rd_out, 0);
    chk("drain_iso_wait", isolated, 0);
    tick(); settle();
    chk("drain_iso_rise", isolated, 1);
    slv_req.ar_valid = 1'b0;
    isolate = 1'b0;
    tick();

    // Hold: AW stalled downstream when isolation is requested
    clear_inputs();
    slv_req.aw.id    = 4'd3;
    slv_req.aw_valid = 1'b1;
    tick();
    isolate = 1'b1;
    tick(); settle();
    chk("hold_aw_valid", mst_req.aw_valid, 1);
    chk("hold_wr0", wr_out, 0);
    tick(); settle();
    chk("hold_aw_still", mst_req.aw_valid, 1);
    chk("hold_not_iso", isolated, 0);
    mst_resp.aw_ready = 1'b1;
    settle();
    chk("hold_slv_ready", slv_resp.aw_ready, 1);
    tick();
    slv_req.aw_valid = 1'b0;
    settle();
    chk("hold_wr1", wr_out, 1);
    chk("hold_aw_closed", slv_resp.aw_ready, 0);
    slv_req.w_valid  = 1'b1;
    slv_req.w.last   = 1'b0;
    mst_resp.w_ready = 1'b1;
    settle();
    chk("hold_w_pass", mst_req.w_valid, 1);
    tick();
    slv_req.w.last = 1'b1;
    tick();
    slv_req.w_valid  = 1'b0;
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id    = 4'd3;
    slv_req.b_ready  = 1'b1;
    settle();
    chk("hold_b_pass", slv_resp.b_valid, 1);
    chk("hold_wait_b", isolated, 0);
    tick();
    mst_resp.b_valid = 1'b0;
    settle();
    chk("hold_wr_back0", wr_out, 0);
    chk("hold_iso_wait", isolated, 0);
    tick(); settle();
    chk("hold_iso_rise", isolated, 1);
    isolate = 1'b0;
    tick();

    // Saturation at eight outstanding writes
    clear_inputs();
    mst_resp.aw_ready = 1'b1;
    slv_req.aw_valid  = 1'b1;
    repeat (8) tick();
    settle();
    chk("sat_wr8", wr_out, 8);
    chk("sat_aw_ready", slv_resp.aw_ready, 0);
    chk("sat_mst_aw", mst_req.aw_valid, 0);
    mst_resp.b_valid = 1'b1;
    slv_req.b_ready  = 1'b1;
    tick(); settle();
    chk("sat_b_only", wr_out, 7);
    chk("sat_aw_reopen", slv_resp.aw_ready, 1);
    tick(); settle();
    chk("sat_aw_and_b", wr_out, 7);
    mst_resp.b_valid = 1'b0;
    tick(); settle();
    chk("sat_wr8_again", wr_out, 8);

    // Reset mid-write with two writes outstanding
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    mst_resp.aw_ready = 1'b1;
    slv_req.aw_valid  = 1'b1;
    tick(); tick();
    slv_req.aw_valid = 1'b0;
    settle();
    chk("mid_wr2", wr_out, 2);
    slv_req.w_valid  = 1'b1;
    mst_resp.w_ready = 1'b1;
    tick();
    rst = 1'b1;
    settle();
    chk("mid_rst_w_ready", slv_resp.w_ready, 0);
    tick();
    clear_inputs();
    rst = 1'b0;
    settle();
    chk("post_rst_wr", wr_out, 0);
    chk("post_rst_rd", rd_out, 0);
    chk("post_rst_iso", isolated, 0);
    chk("post_rst_aw_valid", mst_req.aw_valid, 0);
    chk("post_rst_w_valid", mst_req.w_valid, 0);
    slv_req.aw_valid = 1'b1;
    settle();
    chk("post_rst_run", mst_req.aw_valid, 1);
    clear_inputs();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
